simd_pipe: RTL

- Parametrised, pipelined successor of the single-cycle vector and scalar SIMD ALUs.
- Accepts one LANES-wide operand packet per cycle over a valid/ready handshake.
- Performs a lane-wise op in vector mode (in1 op in2) or scalar mode (in1 op broadcast constant).
- Returns results two cycles later with per-lane overflow flags.
- Sits between the operand buffers and the result writeback of the accelerator datapath.

---
 rtl/simd_pkg.sv | 26 ++
 rtl/simd_pipe_if.sv | 31 +++
 rtl/simd_lane.sv | 54 +++++
 rtl/simd_pipe.sv | 82 ++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD pipeline: op codes and saturation limits.
package simd_pkg;

    localparam int unsigned OP_W = 3;

    // Codes 6 and 7 are reserved and fall through to NOP behaviour.
    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_THR = 3'd4,
        OP_CMP = 3'd5
    } op_e;

    // Largest signed value representable in w bits.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in w bits.
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/simd_pipe_if.sv
// Operand/result handshake bundle for simd_pipe.
interface simd_pipe_if
    import simd_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          op;
    logic                     scalar_mode;
    logic [LANES*WIDTH-1:0]   in1;
    logic [LANES*WIDTH-1:0]   in2;
    logic [WIDTH-1:0]         constant;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out;
    logic [LANES-1:0]         out_ovf;

    // Pipeline side.
    modport slave (
        input  in_valid, op, scalar_mode, in1, in2, constant, out_ready,
        output in_ready, out_valid, out, out_ovf
    );

    // Producer/consumer side.
    modport master (
        output in_valid, op, scalar_mode, in1, in2, constant, out_ready,
        input  in_ready, out_valid, out, out_ovf
    );
endinterface

// File: rtl/simd_lane.sv
// Combinational single-lane ALU. Build option: SIMD_PIPE_SATURATE_EN clamps
// overflowing ADD/SUB/MUL results instead of wrapping them.
module simd_lane
    import simd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [OP_W-1:0]         op,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);
    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    logic signed [W1-1:0] sum;
    logic signed [W1-1:0] diff;
    logic signed [W2-1:0] prod;
    logic                 sum_ovf;
    logic                 diff_ovf;
    logic                 prod_ovf;

    // Exact-width arithmetic; overflow when the top bits are not a sign extension.
    assign sum      = W1'(a) + W1'(b);
    assign diff     = W1'(a) - W1'(b);
    assign prod     = W2'(a) * W2'(b);
    assign sum_ovf  = sum[W1-1] != sum[WIDTH-1];
    assign diff_ovf = diff[W1-1] != diff[WIDTH-1];
    assign prod_ovf = (prod[W2-1:WIDTH-1] != '0) && (prod[W2-1:WIDTH-1] != '1);

    // Op select, with optional clamp toward the sign of the exact result.
    always_comb begin
        result = a;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin result = sum[WIDTH-1:0];  ovf = sum_ovf;  end
            OP_SUB: begin result = diff[WIDTH-1:0]; ovf = diff_ovf; end
            OP_MUL: begin result = prod[WIDTH-1:0]; ovf = prod_ovf; end
            OP_THR: result = (a > b) ? a : b;
            OP_CMP: result = (a > b) ? WIDTH'(1) : '0;
            default: ;
        endcase
`ifdef SIMD_PIPE_SATURATE_EN
        if (ovf) begin
            if ((op == OP_MUL) ? prod[W2-1] : (op == OP_SUB) ? diff[W1-1] : sum[W1-1])
                result = WIDTH'(sat_min(WIDTH));
            else
                result = WIDTH'(sat_max(WIDTH));
        end
`else
`endif
    end
endmodule

// File: rtl/simd_pipe.sv
// Two-stage pipelined SIMD ALU with valid/ready flow control and a
// completed-result counter. Build option: SIMD_PIPE_SATURATE_EN (see simd_lane).
module simd_pipe
    import simd_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    simd_pipe_if.slave       bus,
    output logic [CNT_W-1:0] ops_done
);
    localparam int unsigned VW = LANES * WIDTH;

    logic            s1_valid;
    logic [OP_W-1:0] s1_op;
    logic [VW-1:0]   s1_a;
    logic [VW-1:0]   s1_b;
    logic [VW-1:0]   b_sel;
    logic [VW-1:0]   res;
    logic [LANES-1:0] res_ovf;
    logic            s2_can_load;

    // Operand b is resolved at the input so S1 only carries two vectors.
    assign b_sel = bus.scalar_mode ? {LANES{bus.constant}} : bus.in2;

    assign s2_can_load  = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_can_load;

    // Lane array computing S2's next contents from S1.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane #(.WIDTH(WIDTH)) u_lane (
            .a      (s1_a[i*WIDTH +: WIDTH]),
            .b      (s1_b[i*WIDTH +: WIDTH]),
            .op     (s1_op),
            .result (res[i*WIDTH +: WIDTH]),
            .ovf    (res_ovf[i])
        );
    end

    // S1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op <= bus.op;
                s1_a  <= bus.in1;
                s1_b  <= b_sel;
            end
        end
    end

    // S2: result register driving the output port; holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_ovf   <= '0;
        end else if (s2_can_load) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out     <= res;
                bus.out_ovf <= res_ovf;
            end
        end
    end

    // Count of results accepted downstream; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ops_done <= '0;
        else if (bus.out_valid && bus.out_ready)
            ops_done <= ops_done + CNT_W'(1);
    end
endmodule
